add32_stream_stage: RTL and testbench
=====================================

# add32_stream_stage

Two-stage valid/ready pipeline wrapper around the team's combinational 32-bit carry-lookahead adder. The block sits in front of and behind that adder:
- It registers incoming operand pairs and drives them onto the adder's `a`/`b`/`cin`.
- It captures the adder's `sum`/`cout` into an output register with backpressure.
- It keeps a running accumulator so a stream of operands can be summed without a host read-back.

Throughput is one add per cycle. The adder instance is outside this block and connects through the `add_*` ports.

## Interface
Parameters: none. Datapath width is fixed at 32 to match the adder.

Ports:
- `clk` — input, 1 — single clock, all state on rising edge.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `in_valid` — input, 1 — operand pair present.
- `in_ready` — output, 1 — block can accept an operand pair this cycle.
- `in_a` — input, 32 — operand A; ignored when `in_acc`=1.
- `in_b` — input, 32 — operand B.
- `in_cin` — input, 1 — carry-in.
- `in_acc` — input, 1 — accumulate mode: use the accumulator as operand A.
- `acc_clr` — input, 1 — synchronous accumulator clear.
- `add_a` — output, 32 — to adder `a`.
- `add_b` — output, 32 — to adder `b`.
- `add_cin` — output, 1 — to adder `cin`.
- `add_sum` — input, 32 — from adder `sum`.
- `add_cout` — input, 1 — from adder `cout`.
- `out_valid` — output, 1 — result present.
- `out_ready` — input, 1 — consumer accepts the result.
- `out_sum` — output, 32 — registered sum.
- `out_cout` — output, 1 — registered unsigned carry-out.
- `out_ovf` — output, 1 — registered signed (two's-complement) overflow.
- `busy` — output, 1 — `s1_valid | s2_valid`.

## Operation
Stage S1 (operand register) holds `s1_valid`, `s1_a`, `s1_b`, `s1_cin`.
- `add_a`/`add_b`/`add_cin` are driven directly from these registers.

Stage S2 (result register) holds `s2_valid`, `out_sum`, `out_cout`, `out_ovf`.

Handshakes:
- `s1_adv` = `s1_valid & (!s2_valid | out_ready)`.
- `in_ready` = `rst_n & (!s1_valid | s1_adv)`.
- Input accept = `in_valid & in_ready`. Output handshake = `out_valid & out_ready`.

On input accept:
- S1 loads `in_b` and `in_cin`.
- S1 loads operand A as follows:
  - `in_acc`=0: `in_a`.
  - `in_acc`=1 and `s1_adv`=1: `add_sum` (forwarding, no stall).
  - `in_acc`=1 and `s1_adv`=0: `acc`.

On `s1_adv`:
- S2 loads `add_sum` and `add_cout`.
- S2 loads `out_ovf` = `(s1_a[31]==s1_b[31]) & (add_sum[31]!=s1_a[31])`.
- Set `s2_valid`=1.

Other S1/S2 transitions:
- `s1_valid` clears on `s1_adv` without a new accept.
- `s2_valid` clears on output handshake without a new `s1_adv`.
- Simultaneous handshake and `s1_adv` reloads S2 with `s2_valid` staying 1.

Accumulator `acc` (32-bit, internal):
- Loads `add_sum` on every `s1_adv`, regardless of `in_acc`.
- `acc_clr`=1 forces `acc` to 0 on the next edge and overrides a simultaneous `s1_adv` load.
- An `in_acc` operand accepted in the same cycle as `acc_clr` uses the pre-clear value (forwarded or `acc`).

Arithmetic:
- Modulo 2^32; carry reported only via `out_cout`.
- `cin` is independent of `in_acc`.

S1 and S2 payload registers hold their values while their valid is low; there is no data gating.

## Timing
Reset (`rst_n` low, asynchronous):
- All registers go to 0: `s1_*`, `s2_*`, `acc`.
- Outputs read `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, `add_a`=0, `add_b`=0, `add_cin`=0, `busy`=0.
- An operation in flight when reset asserts is discarded, with no partial output.
- After `rst_n` rises, `in_ready`=1 in the first cycle.

Latency:
- Operand accepted at edge t appears on `add_*` after edge t.
- The result is captured at edge t+1, so `out_valid`=1 in the cycle after edge t+1.
- Earliest output handshake is at edge t+2.

Throughput:
- One operation per cycle while `out_ready`=1.
- With `out_ready`=0, the block absorbs two operations (S1+S2), then `in_ready`=0.
- `in_ready` returns to 1 in the same cycle `out_ready` rises (combinational path through `s1_adv`).

Stability:
- `out_valid`/`out_sum`/`out_cout`/`out_ovf` stay stable while `out_valid & !out_ready`.

Combinational paths:
- `out_ready` → `in_ready`.
- `add_sum` → S1 operand-A mux (the adder's CLA delay plus the mux must close in one cycle).

## Test plan
- **Reset/idle.** Assert `rst_n`=0 mid-stream with S1 and S2 full → all outputs 0 immediately; after release, `in_ready`=1, `out_valid`=0.
- **Single add.** Send a=0x0000_0005, b=0x0000_0003, cin=1 → after 2 edges: `out_sum`=0x0000_0009, `out_cout`=0, `out_ovf`=0.
- **Carry and overflow.** Send 0xFFFF_FFFF+0x0000_0001 → sum=0x0000_0000, cout=1, ovf=0. Send 0x7FFF_FFFF+0x0000_0001 → sum=0x8000_0000, cout=0, ovf=1.
- **Back-to-back accumulate with forwarding.**
  - Set `acc_clr` for one cycle, then stream b=1,2,3,4 with `in_acc`=1, cin=0, `out_ready`=1, on consecutive cycles.
  - Required: outputs 1,3,6,10, one per cycle, `in_ready` never drops.
- **Backpressure.**
  - Hold `out_ready`=0 and offer 4 operands → only 2 accepted, `in_ready`=0, `out_sum` stable.
  - Release `out_ready` → all 4 results emerge in order, with no loss or duplication.
- **Clear collision.** Assert `acc_clr` in the same cycle as an `s1_adv` producing 0x10 → next cycle `acc`=0; a following `in_acc` op with b=7 yields 7.

Source files
------------

// File: rtl/add32_stream_if.sv
// Handshake and adder-side signal bundle for add32_stream_stage.
// Both streams use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and payload
// steady until that edge, and ready may depend combinationally on the
// consumer side.
interface add32_stream_if;
  // Operand stream (producer -> block)
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_acc;
  logic        acc_clr;
  // External carry-lookahead adder
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  // Result stream (block -> consumer)
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  // Environment side: operand producer, result consumer and the adder itself
  modport master (
    output in_valid, in_a, in_b, in_cin, in_acc, acc_clr,
    input  in_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  out_valid, out_sum, out_cout, out_ovf, busy,
    output out_ready
  );

  // The pipeline stage
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_acc, acc_clr,
    output in_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output out_valid, out_sum, out_cout, out_ovf, busy,
    input  out_ready
  );
endinterface

// File: rtl/add32_stream_stage.sv
// Two-stage valid/ready wrapper around an external 32-bit adder.
// S1 registers operands and drives the adder; S2 captures the result with
// backpressure. A running accumulator can replace operand A, and it is
// forwarded straight from the adder output when the previous op is moving
// into S2 in the same cycle.
module add32_stream_stage (
  input  logic          clk,
  input  logic          rst_n,
  add32_stream_if.slave bus
);

  logic        r_s1_valid;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic        r_s1_cin;

  logic        r_s2_valid;
  logic [31:0] r_s2_sum;
  logic        r_s2_cout;
  logic        r_s2_ovf;

  logic [31:0] r_acc;

  logic        w_s1_adv;
  logic        w_in_accept;
  logic        w_out_hs;
  logic [31:0] w_op_a;
  logic        w_ovf;

  // Handshake decode, operand-A select and signed-overflow detection
  always_comb begin
    w_s1_adv    = r_s1_valid & (~r_s2_valid | bus.out_ready);
    bus.in_ready = rst_n & (~r_s1_valid | w_s1_adv);
    w_in_accept = bus.in_valid & bus.in_ready;
    w_out_hs    = r_s2_valid & bus.out_ready;
    w_op_a      = bus.in_a;
    if (bus.in_acc) begin
      // The accumulator is stale while the previous op is in the adder,
      // so take that op's sum directly when it is leaving S1 this cycle.
      w_op_a = w_s1_adv ? bus.add_sum : r_acc;
    end
    w_ovf = (r_s1_a[31] == r_s1_b[31]) & (bus.add_sum[31] != r_s1_a[31]);
  end

  // S1 operand register; payload holds while valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
    end else if (w_in_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= w_op_a;
      r_s1_b     <= bus.in_b;
      r_s1_cin   <= bus.in_cin;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 result register; a new result may replace one leaving the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_cout  <= 1'b0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_sum   <= bus.add_sum;
      r_s2_cout  <= bus.add_cout;
      r_s2_ovf   <= w_ovf;
    end else if (w_out_hs) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Accumulator follows every completed add; clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
    end else if (w_s1_adv) begin
      r_acc <= bus.add_sum;
    end
  end

  assign bus.add_a     = r_s1_a;
  assign bus.add_b     = r_s1_b;
  assign bus.add_cin   = r_s1_cin;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_sum   = r_s2_sum;
  assign bus.out_cout  = r_s2_cout;
  assign bus.out_ovf   = r_s2_ovf;
  assign bus.busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_add32_stream_stage.sv
// Bench for add32_stream_stage: behavioural adder, directed operand stream,
// queue-based reference model and a single negedge compare process.
module tb_add32_stream_stage;

  logic clk;
  logic rst_n;

  add32_stream_if bus ();

  add32_stream_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Adder outside the block: plain 33-bit addition
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: {ovf, cout, sum} per accepted operation, in order
  logic [33:0] exp_q[$];
  logic [34:0] lit_q[$];   // {enable, ovf, cout, sum} hand-computed pins
  logic [31:0] m_acc;
  logic        cur_lit_en;
  logic [33:0] cur_lit;
  logic        stall_prev;
  logic [33:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compare process: model update and output checks on every falling edge
  always @(negedge clk) begin
    logic [33:0] e;
    logic [34:0] l;
    logic [32:0] r;
    logic [31:0] a;
    logic [33:0] cur;
    if (rst_n) begin
      cur = {bus.out_ovf, bus.out_cout, bus.out_sum};
      if (stall_prev) begin
        chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_data", {30'd0, cur}, {30'd0, prev_out});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {30'd0, cur}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          l = lit_q.pop_front();
          chk("result", {30'd0, cur}, {30'd0, e});
          if (l[34]) chk("result_lit", {30'd0, cur}, {30'd0, l[33:0]});
        end
      end
      stall_prev = bus.out_valid & ~bus.out_ready;
      prev_out   = cur;
      if (bus.in_valid && bus.in_ready) begin
        a = bus.in_acc ? m_acc : bus.in_a;
        r = {1'b0, a} + {1'b0, bus.in_b} + {32'd0, bus.in_cin};
        exp_q.push_back({(a[31] == bus.in_b[31]) && (r[31] != a[31]), r[32], r[31:0]});
        lit_q.push_back({cur_lit_en, cur_lit});
        m_acc = r[31:0];
      end else if (bus.acc_clr) begin
        m_acc = '0;
      end
    end
  end

  task automatic model_flush();
    exp_q.delete();
    lit_q.delete();
    m_acc      = '0;
    stall_prev = 1'b0;
  endtask

  // Driver: present one operand pair and hold it until accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic acc, input logic lit_en, input logic [33:0] lit,
                      output int waits);
    cur_lit_en   = lit_en;
    cur_lit      = lit;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_acc   = acc;
    bus.in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_acc   = 1'b0;
    cur_lit_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_out_sum"}, {32'd0, bus.out_sum}, 64'd0);
    chk({tag, "_out_cout"}, {63'd0, bus.out_cout}, 64'd0);
    chk({tag, "_out_ovf"}, {63'd0, bus.out_ovf}, 64'd0);
    chk({tag, "_add_a"}, {32'd0, bus.add_a}, 64'd0);
    chk({tag, "_add_b"}, {32'd0, bus.add_b}, 64'd0);
    chk({tag, "_add_cin"}, {63'd0, bus.add_cin}, 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int w;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_acc    = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    cur_lit_en    = 1'b0;
    cur_lit       = '0;
    prev_out      = '0;
    model_flush();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Single add, carry, overflow
    send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b1, {2'b00, 32'h0000_0009}, w);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b01, 32'h0000_0000}, w);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b10, 32'h8000_0000}, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, {2'b11, 32'h0000_0000}, w);
    drain("drain_basic");

    // Back-to-back accumulate with forwarding
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    send(32'hAAAA_AAAA, 32'd1, 1'b0, 1'b1, 1'b1, {2'b00, 32'd1}, w);
    chk("acc_wait1", 64'(w), 64'd0);
    send(32'hAAAA_AAAA, 32'd2, 1'b0, 1'b1, 1'b1, {2'b00, 32'd3}, w);
    chk("acc_wait2", 64'(w), 64'd0);
    send(32'hAAAA_AAAA, 32'd3, 1'b0, 1'b1, 1'b1, {2'b00, 32'd6}, w);
    chk("acc_wait3", 64'(w), 64'd0);
    send(32'hAAAA_AAAA, 32'd4, 1'b0, 1'b1, 1'b1, {2'b00, 32'd10}, w);
    chk("acc_wait4", 64'(w), 64'd0);
    drain("drain_acc");

    // Backpressure: two ops absorbed, third held off until out_ready rises
    bus.out_ready = 1'b0;
    send(32'h100, 32'h1, 1'b0, 1'b0, 1'b1, {2'b00, 32'h101}, w);
    send(32'h200, 32'h2, 1'b0, 1'b0, 1'b1, {2'b00, 32'h202}, w);
    chk("bp_second_accept", 64'(w), 64'd0);
    bus.in_a     = 32'h300;
    bus.in_b     = 32'h3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_out_sum_held", {32'd0, bus.out_sum}, 64'h101);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h300, 32'h3, 1'b0, 1'b0, 1'b1, {2'b00, 32'h303}, w);
    chk("bp_release_same_cycle", 64'(w), 64'd0);
    send(32'h400, 32'h4, 1'b0, 1'b0, 1'b1, {2'b00, 32'h404}, w);
    drain("drain_bp");

    // Clear colliding with the advance of a 0x10 result
    send(32'h8, 32'h8, 1'b0, 1'b0, 1'b1, {2'b00, 32'h10}, w);
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    send(32'hFFFF_0000, 32'd7, 1'b0, 1'b1, 1'b1, {2'b00, 32'd7}, w);
    drain("drain_clr");

    // In-acc op accepted together with a clear uses the pre-clear value
    send(32'd5, 32'd0, 1'b0, 1'b0, 1'b1, {2'b00, 32'd5}, w);
    bus.acc_clr = 1'b1;
    send(32'd0, 32'd1, 1'b0, 1'b1, 1'b1, {2'b00, 32'd6}, w);
    bus.acc_clr = 1'b0;
    send(32'd0, 32'd0, 1'b1, 1'b1, 1'b1, {2'b00, 32'd7}, w);
    drain("drain_clr_fwd");

    // Reset mid-stream with both stages full
    bus.out_ready = 1'b0;
    send(32'h11, 32'h22, 1'b0, 1'b0, 1'b0, '0, w);
    send(32'h33, 32'h44, 1'b1, 1'b0, 1'b0, '0, w);
    chk("full_busy", {63'd0, bus.busy}, 64'd1);
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_flush();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    // Accumulator restarts from zero; cin still applies in accumulate mode
    send(32'h5555_5555, 32'd3, 1'b1, 1'b1, 1'b1, {2'b00, 32'd4}, w);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
